data_ram_resp: RTL and testbench

- Responder end of the decode-stage data-memory read interface (mem_rd_req / mem_rd_addr) and of the store write path from execute.
- Holds the word-organised data RAM and services one load at a time with a configurable wait-state counter.
- Returns the full aligned word with a valid pulse; byte/half extraction and sign extension stay downstream.
- Drives a busy flag so the pipeline stalls while a load is outstanding.

---
 rtl/data_ram_resp.sv | 163 ++++++++++++++++
 tb/tb_data_ram_resp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_resp.sv
// rtl/data_ram_resp.sv - word-organised data RAM responder for loads (wait-state FSM) and stores
// Optional: DATA_RAM_ADDR_CHECK_EN enables out-of-range address detection on mem_err_o.
module data_ram_resp #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_rd_req_i,
    input  logic [WIDTH-1:0]     mem_rd_addr_i,
    output logic [WIDTH-1:0]     mem_rd_data_o,
    output logic                 mem_rd_valid_o,
    output logic                 mem_busy_o,
    input  logic                 mem_wr_req_i,
    input  logic [WIDTH-1:0]     mem_wr_addr_i,
    input  logic [WIDTH-1:0]     mem_wr_data_i,
    input  logic [WIDTH/8-1:0]   mem_wr_strb_i,
    output logic                 mem_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             rerr_q, rerr_d;
    logic [WIDTH-1:0] data_q;

    logic [AW-1:0]    rd_idx_in;
    logic [AW-1:0]    wr_idx;
    logic             rd_oob_in;
    logic             wr_oob;
    logic             wr_en;
    logic             load;
    logic [AW-1:0]    load_idx;
    logic             load_err;
    logic [WIDTH-1:0] merged;

    // Byte-offset bits (and high bits in the wrapping build) carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^{mem_rd_addr_i, mem_wr_addr_i};

    assign rd_idx_in = mem_rd_addr_i[AW+1:2];
    assign wr_idx    = mem_wr_addr_i[AW+1:2];

`ifdef DATA_RAM_ADDR_CHECK_EN
    assign rd_oob_in = |(mem_rd_addr_i >> (AW + 2));
    assign wr_oob    = |(mem_wr_addr_i >> (AW + 2));
`else
    assign rd_oob_in = 1'b0;
    assign wr_oob    = 1'b0;
`endif

    // Out-of-range stores are dropped entirely, so they also never merge into a load.
    assign wr_en = mem_wr_req_i && !wr_oob;

    // Store path: per-lane write, independent of the load FSM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_wr_strb_i[b]) begin
                    mem[wr_idx][8*b +: 8] <= mem_wr_data_i[8*b +: 8];
                end
            end
        end
    end

    // Write-first merge of a same-edge store into the word a load captures.
    always_comb begin
        merged = mem[load_idx];
        for (int b = 0; b < NB; b++) begin
            if (wr_en && (wr_idx == load_idx) && mem_wr_strb_i[b]) begin
                merged[8*b +: 8] = mem_wr_data_i[8*b +: 8];
            end
        end
    end

    // Next-state and control: accept in IDLE/RESP, count down in WAIT.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        rerr_d         = rerr_q;
        load           = 1'b0;
        load_idx       = idx_q;
        load_err       = rerr_q;
        mem_rd_valid_o = 1'b0;
        mem_busy_o     = 1'b0;
        case (state_q)
            WAIT: begin
                mem_busy_o = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                mem_rd_valid_o = (state_q == RESP);
                if (mem_rd_req_i) begin
                    idx_d  = rd_idx_in;
                    rerr_d = rd_oob_in;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = RESP;
                        load     = 1'b1;
                        load_idx = rd_idx_in;
                        load_err = rd_oob_in;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // FSM registers and the response word, captured only on RESP entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            rerr_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rerr_q  <= rerr_d;
            if (load) begin
                data_q <= load_err ? '0 : merged;
            end
        end
    end

    assign mem_rd_data_o = data_q;

`ifdef DATA_RAM_ADDR_CHECK_EN
    logic err_q;

    // Load and store errors share one registered pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (load && load_err) || (mem_wr_req_i && wr_oob);
        end
    end

    assign mem_err_o = err_q;
`else
    assign mem_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_data_ram_resp.sv
// tb/tb_data_ram_resp.sv - self-checking bench for data_ram_resp (WAIT_CYCLES 0, 2 and 3)
module tb_data_ram_resp;
`ifdef DATA_RAM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        wr_req = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;

    logic [31:0] d0, d2, d3;
    logic        v0, v2, v3, b0, b2, b3, e0, e2, e3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_ram_resp #(.WIDTH(32), .DEPTH(4096), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_rd_req_i(rd_req), .mem_rd_addr_i(rd_addr),
        .mem_rd_data_o(d0), .mem_rd_valid_o(v0), .mem_busy_o(b0),
        .mem_wr_req_i(wr_req), .mem_wr_addr_i(wr_addr), .mem_wr_data_i(wr_data),
        .mem_wr_strb_i(wr_strb), .mem_err_o(e0));

    data_ram_resp #(.WIDTH(32), .DEPTH(4096), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .mem_rd_req_i(rd_req), .mem_rd_addr_i(rd_addr),
        .mem_rd_data_o(d2), .mem_rd_valid_o(v2), .mem_busy_o(b2),
        .mem_wr_req_i(wr_req), .mem_wr_addr_i(wr_addr), .mem_wr_data_i(wr_data),
        .mem_wr_strb_i(wr_strb), .mem_err_o(e2));

    data_ram_resp #(.WIDTH(32), .DEPTH(4096), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .mem_rd_req_i(rd_req), .mem_rd_addr_i(rd_addr),
        .mem_rd_data_o(d3), .mem_rd_valid_o(v3), .mem_busy_o(b3),
        .mem_wr_req_i(wr_req), .mem_wr_addr_i(wr_addr), .mem_wr_data_i(wr_data),
        .mem_wr_strb_i(wr_strb), .mem_err_o(e3));

    typedef struct {
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        rd;
        logic [31:0] raddr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl[NV];
    logic [31:0] sb[$];

    function automatic vec_t mk(input logic wr, input logic [31:0] waddr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic rd, input logic [31:0] raddr,
                                input logic [31:0] exp_data, input logic exp_err);
        vec_t v;
        v.wr = wr; v.waddr = waddr; v.wdata = wdata; v.strb = strb;
        v.rd = rd; v.raddr = raddr; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        wr_req = 1'b1; wr_addr = a; wr_data = d; wr_strb = 4'hF;
        step();
        wr_req = 1'b0; wr_strb = 4'h0;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives a one-cycle load on dut3 and returns edges until valid (0 on timeout).
    task automatic load3(input logic [31:0] a, output int lat);
        lat = 0;
        rd_req = 1'b1; rd_addr = a;
        for (int n = 1; n <= 12; n++) begin
            step();
            rd_req = 1'b0;
            if (v3 && lat == 0) lat = n;
        end
    endtask

    initial begin
        int lat;
        int seen;
        idle_inputs();

        // Reset state, asynchronous, before any clock edge.
        #2;
        chk("rst_data0", d0, 32'h0);
        chk("rst_valid0", {31'b0, v0}, 32'h0);
        chk("rst_busy0", {31'b0, b0}, 32'h0);
        chk("rst_err0", {31'b0, e0}, 32'h0);
        chk("rst_busy3", {31'b0, b3}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // WAIT_CYCLES=0 table: store/load, back-to-back, collision, strobes, wrap or error.
        tbl[0]  = mk(1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 32'h0,    32'h0, 0);
        tbl[1]  = mk(0, 32'h0,    32'h0,        4'h0, 1, 32'h13,   32'hDEADBEEF, 0);
        tbl[2]  = mk(1, 32'h0,    32'h00000001, 4'hF, 0, 32'h0,    32'h0, 0);
        tbl[3]  = mk(1, 32'h4,    32'h00000002, 4'hF, 0, 32'h0,    32'h0, 0);
        tbl[4]  = mk(1, 32'h8,    32'h00000003, 4'hF, 0, 32'h0,    32'h0, 0);
        tbl[5]  = mk(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,    32'h00000001, 0);
        tbl[6]  = mk(0, 32'h0,    32'h0,        4'h0, 1, 32'h4,    32'h00000002, 0);
        tbl[7]  = mk(0, 32'h0,    32'h0,        4'h0, 1, 32'h8,    32'h00000003, 0);
        tbl[8]  = mk(1, 32'h20,   32'h11223344, 4'hF, 0, 32'h0,    32'h0, 0);
        tbl[9]  = mk(1, 32'h20,   32'hAABBCCDD, 4'h3, 1, 32'h20,   32'h1122CCDD, 0);
        tbl[10] = mk(0, 32'h0,    32'h0,        4'h0, 1, 32'h20,   32'h1122CCDD, 0);
        tbl[11] = mk(1, 32'h24,   32'h55667788, 4'hF, 0, 32'h0,    32'h0, 0);
        tbl[12] = mk(1, 32'h24,   32'hFFFFFFFF, 4'h0, 1, 32'h10,   32'hDEADBEEF, 0);
        tbl[13] = mk(0, 32'h0,    32'h0,        4'h0, 1, 32'h24,   32'h55667788, 0);
        tbl[14] = mk(0, 32'h24,   32'h00000000, 4'hF, 1, 32'h26,   32'h55667788, 0);
        tbl[15] = mk(0, 32'h0,    32'h0,        4'h0, 1, 32'h24,   32'h55667788, 0);
        tbl[16] = mk(1, 32'h4000, 32'h99999999, 4'hF, 0, 32'h0,    32'h0, CHK);
        tbl[17] = mk(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,    CHK ? 32'h00000001 : 32'h99999999, 0);
        tbl[18] = mk(0, 32'h0,    32'h0,        4'h0, 1, 32'h4000, CHK ? 32'h00000000 : 32'h99999999, CHK);
        tbl[19] = mk(0, 32'h0,    32'h0,        4'h0, 1, 32'h8,    32'h00000003, 0);
        tbl[20] = mk(1, 32'h4008, 32'h77777777, 4'hF, 1, 32'h4008, CHK ? 32'h00000000 : 32'h77777777, CHK);
        tbl[21] = mk(0, 32'h0,    32'h0,        4'h0, 1, 32'h8,    CHK ? 32'h00000003 : 32'h77777777, 0);

        for (int i = 0; i < NV; i++) begin
            wr_req = tbl[i].wr; wr_addr = tbl[i].waddr; wr_data = tbl[i].wdata; wr_strb = tbl[i].strb;
            rd_req = tbl[i].rd; rd_addr = tbl[i].raddr;
            if (tbl[i].rd) sb.push_back(tbl[i].exp_data);
            step();
            chk($sformatf("t%0d_valid", i), {31'b0, v0}, {31'b0, tbl[i].rd});
            chk($sformatf("t%0d_busy", i), {31'b0, b0}, 32'h0);
            chk($sformatf("t%0d_err", i), {31'b0, e0}, {31'b0, tbl[i].exp_err});
            if (v0) begin
                if (sb.size() == 0) begin
                    chk($sformatf("t%0d_unexpected_valid", i), 32'h1, 32'h0);
                end else begin
                    chk($sformatf("t%0d_data", i), d0, sb.pop_front());
                end
            end
        end
        idle_inputs();
        chk("sb_drained", sb.size(), 32'h0);

        // WAIT_CYCLES=2: busy for two cycles, request change ignored, data held afterwards.
        pulse_reset();
        write_word(32'h10, 32'hCAFEF00D);
        write_word(32'h18, 32'h00000000);
        rd_req = 1'b1; rd_addr = 32'h10;
        step();
        chk("w2_busy1", {30'b0, b2, v2}, 32'h2);
        rd_addr = 32'h14;
        step();
        chk("w2_busy2", {30'b0, b2, v2}, 32'h2);
        rd_req = 1'b0;
        step();
        chk("w2_resp", {30'b0, b2, v2}, 32'h1);
        chk("w2_data", d2, 32'hCAFEF00D);
        step();
        chk("w2_idle", {30'b0, b2, v2}, 32'h0);
        chk("w2_hold", d2, 32'hCAFEF00D);

        // Store landing during WAIT is seen by the pending load.
        rd_req = 1'b1; rd_addr = 32'h18;
        step();
        rd_req = 1'b0;
        wr_req = 1'b1; wr_addr = 32'h18; wr_data = 32'h12345678; wr_strb = 4'hF;
        step();
        wr_req = 1'b0; wr_strb = 4'h0;
        step();
        chk("w2_wait_store_valid", {31'b0, v2}, 32'h1);
        chk("w2_wait_store_data", d2, 32'h12345678);

        // WAIT_CYCLES=3: full load, then reset while in WAIT.
        pulse_reset();
        write_word(32'h30, 32'hA5A5A5A5);
        load3(32'h30, lat);
        chk("w3_latency", lat, 32'd4);
        chk("w3_data", d3, 32'hA5A5A5A5);
        rd_req = 1'b1; rd_addr = 32'h30;
        step();
        rd_req = 1'b0;
        chk("w3_busy", {31'b0, b3}, 32'h1);
        step();
        #2 rst = 1'b1;
        #1;
        chk("w3_rst_outputs", {d3[31:3], e3, b3, v3}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (v3 || b3) seen++;
        end
        chk("w3_no_valid_after_rst", seen, 32'h0);
        load3(32'h30, lat);
        chk("w3_latency_after_rst", lat, 32'd4);
        chk("w3_ram_preserved", d3, 32'hA5A5A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
